// File: rtl/aurora_pkg.sv
// Shared definitions for the Aurora TX arbiter: FSM encoding, channel IDs, counter width.
// Pure declarations; no logic, no latency, no backpressure.
package aurora_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

  localparam logic CH_WRITE = 1'b0;
  localparam logic CH_READ  = 1'b1;
  localparam int   CNT_W    = 32;

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry AXI-Stream output register; load to visible in 1 cycle, one beat/cycle sustained.
// Backpressure: holds data/last/id stable while TVALID=1 and TREADY=0; load_rdy drops in that case.
module axis_out_reg #(
  parameter int DW = 256
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          load_vld,
  input  logic [DW-1:0] load_dat,
  input  logic          load_last,
  input  logic          load_id,
  output logic          load_rdy,
  output logic [DW-1:0] M_AXIS_TDATA,
  output logic          M_AXIS_TVALID,
  output logic          M_AXIS_TLAST,
  output logic          M_AXIS_TID,
  input  logic          M_AXIS_TREADY
);

  // Room for a new beat when empty or when the current one drains this cycle.
  assign load_rdy = !M_AXIS_TVALID || M_AXIS_TREADY;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TDATA  <= '0;
      M_AXIS_TLAST  <= 1'b0;
      M_AXIS_TID    <= 1'b0;
    end else if (load_vld) begin
      M_AXIS_TVALID <= 1'b1;
      M_AXIS_TDATA  <= load_dat;
      M_AXIS_TLAST  <= load_last;
      M_AXIS_TID    <= load_id;
    end else if (M_AXIS_TREADY) begin
      M_AXIS_TVALID <= 1'b0;
    end
  end

endmodule

// File: rtl/aurora_tx_arbiter.sv
// Packet-level round-robin merge of write-request (S0) and read-response (S1) streams onto Aurora TX; latency 1.
// Backpressure: only the granted source sees TREADY, tracking output-register room; ARB_PKT_COUNT_EN adds per-channel packet counters.
module aurora_tx_arbiter
  import aurora_pkg::*;
#(
  parameter int DW = 256
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [DW-1:0]    S0_AXIS_TDATA,
  input  logic             S0_AXIS_TVALID,
  input  logic             S0_AXIS_TLAST,
  output logic             S0_AXIS_TREADY,
  input  logic [DW-1:0]    S1_AXIS_TDATA,
  input  logic             S1_AXIS_TVALID,
  input  logic             S1_AXIS_TLAST,
  output logic             S1_AXIS_TREADY,
  output logic [DW-1:0]    M_AXIS_TDATA,
  output logic             M_AXIS_TVALID,
  output logic             M_AXIS_TLAST,
  output logic             M_AXIS_TID,
`ifdef ARB_PKT_COUNT_EN
  output logic [CNT_W-1:0] PKT_COUNT0,
  output logic [CNT_W-1:0] PKT_COUNT1,
`endif
  input  logic             M_AXIS_TREADY
);

  arb_state_t    state;
  logic          last_served;
  logic          out_rdy;
  logic          s0_acc;
  logic          s1_acc;
  logic          load_vld;
  logic [DW-1:0] load_dat;
  logic          load_last;
  logic          load_id;

  // resetn gates TREADY combinationally so nothing is acknowledged during reset.
  assign S0_AXIS_TREADY = resetn && (state == GRANT0) && out_rdy;
  assign S1_AXIS_TREADY = resetn && (state == GRANT1) && out_rdy;

  assign s0_acc    = S0_AXIS_TVALID && S0_AXIS_TREADY;
  assign s1_acc    = S1_AXIS_TVALID && S1_AXIS_TREADY;
  assign load_vld  = s0_acc || s1_acc;
  assign load_dat  = s1_acc ? S1_AXIS_TDATA : S0_AXIS_TDATA;
  assign load_last = s1_acc ? S1_AXIS_TLAST : S0_AXIS_TLAST;
  assign load_id   = s1_acc ? CH_READ : CH_WRITE;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      last_served <= CH_READ;
    end else begin
      case (state)
        IDLE: begin
          if (S0_AXIS_TVALID && S1_AXIS_TVALID)
            state <= (last_served == CH_WRITE) ? GRANT1 : GRANT0;
          else if (S0_AXIS_TVALID)
            state <= GRANT0;
          else if (S1_AXIS_TVALID)
            state <= GRANT1;
        end
        // Grant is held across source bubbles until the packet's last beat.
        GRANT0: begin
          if (s0_acc && S0_AXIS_TLAST) begin
            state       <= IDLE;
            last_served <= CH_WRITE;
          end
        end
        GRANT1: begin
          if (s1_acc && S1_AXIS_TLAST) begin
            state       <= IDLE;
            last_served <= CH_READ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_PKT_COUNT_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      PKT_COUNT0 <= '0;
      PKT_COUNT1 <= '0;
    end else begin
      if (s0_acc && S0_AXIS_TLAST) PKT_COUNT0 <= PKT_COUNT0 + CNT_W'(1);
      if (s1_acc && S1_AXIS_TLAST) PKT_COUNT1 <= PKT_COUNT1 + CNT_W'(1);
    end
  end
`else
  // Packet counters are not built in this configuration.
`endif

  axis_out_reg #(.DW(DW)) u_out_reg (
    .clk          (clk),
    .resetn       (resetn),
    .load_vld     (load_vld),
    .load_dat     (load_dat),
    .load_last    (load_last),
    .load_id      (load_id),
    .load_rdy     (out_rdy),
    .M_AXIS_TDATA (M_AXIS_TDATA),
    .M_AXIS_TVALID(M_AXIS_TVALID),
    .M_AXIS_TLAST (M_AXIS_TLAST),
    .M_AXIS_TID   (M_AXIS_TID),
    .M_AXIS_TREADY(M_AXIS_TREADY)
  );

endmodule

// File: tb/tb_aurora_tx_arbiter.sv
// Directed bench for aurora_tx_arbiter: queued source beats (with bubbles), output beat log, hand-written expectations.
// Counter checks are built only when ARB_PKT_COUNT_EN is defined.
module tb_aurora_tx_arbiter;
  import aurora_pkg::*;

  localparam int DW = 256;

  typedef struct packed {
    logic          vld;
    logic          last;
    logic [DW-1:0] dat;
  } beat_t;

  typedef struct {
    logic [DW-1:0] dat;
    logic          last;
    logic          id;
    int            cyc;
  } obeat_t;

  logic          clk = 1'b0;
  logic          resetn;
  logic [DW-1:0] s_dat[2];
  logic          s_vld[2];
  logic          s_last[2];
  logic          s0_rdy, s1_rdy;
  logic [DW-1:0] m_dat;
  logic          m_vld, m_last, m_id, m_rdy;
`ifdef ARB_PKT_COUNT_EN
  logic [31:0]   cnt0, cnt1;
`endif

  beat_t  sq[2][$];
  obeat_t oq[$];
  logic   fire[2];
  logic   bub[2];
  int     cyc = 0;
  int     acc_cyc;
  logic   mon_early = 1'b0;
  logic   s1_early = 1'b0;
  int     n_chk = 0;
  int     n_fail = 0;

  always #5 clk = ~clk;

  aurora_tx_arbiter #(.DW(DW)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .S0_AXIS_TDATA (s_dat[0]),
    .S0_AXIS_TVALID(s_vld[0]),
    .S0_AXIS_TLAST (s_last[0]),
    .S0_AXIS_TREADY(s0_rdy),
    .S1_AXIS_TDATA (s_dat[1]),
    .S1_AXIS_TVALID(s_vld[1]),
    .S1_AXIS_TLAST (s_last[1]),
    .S1_AXIS_TREADY(s1_rdy),
    .M_AXIS_TDATA  (m_dat),
    .M_AXIS_TVALID (m_vld),
    .M_AXIS_TLAST  (m_last),
    .M_AXIS_TID    (m_id),
`ifdef ARB_PKT_COUNT_EN
    .PKT_COUNT0    (cnt0),
    .PKT_COUNT1    (cnt1),
`endif
    .M_AXIS_TREADY (m_rdy)
  );

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push(input int c, input logic [DW-1:0] d, input logic l);
    sq[c].push_back('{vld: 1'b1, last: l, dat: d});
  endtask

  task automatic push_bub(input int c);
    sq[c].push_back('{vld: 1'b0, last: 1'b0, dat: '0});
  endtask

  task automatic start_reset();
    resetn = 1'b0;
    for (int c = 0; c < 2; c++) begin
      sq[c].delete();
      s_vld[c] = 1'b0;
      bub[c]   = 1'b0;
    end
    oq.delete();
  endtask

  task automatic wait_out(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && oq.size() < n; i++) step(1);
    chk(tag, oq.size(), n);
  endtask

  // Handshakes are judged at the falling edge, when all inputs are stable.
  initial forever begin
    @(negedge clk);
    fire[0] = s_vld[0] && s0_rdy;
    fire[1] = s_vld[1] && s1_rdy;
    if (fire[0] && acc_cyc < 0) acc_cyc = cyc;
    if (resetn && m_vld && m_rdy)
      oq.push_back('{dat: m_dat, last: m_last, id: m_id, cyc: cyc});
    if (mon_early && s1_rdy && sq[0].size() > 0) s1_early = 1'b1;
  end

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial forever begin
    @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++) begin
      if (sq[c].size() > 0 && (fire[c] || bub[c])) void'(sq[c].pop_front());
      bub[c] = 1'b0;
      if (sq[c].size() > 0) begin
        s_vld[c]  = sq[c][0].vld;
        s_dat[c]  = sq[c][0].dat;
        s_last[c] = sq[c][0].last;
        bub[c]    = !sq[c][0].vld;
      end else begin
        s_vld[c] = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [7:0] e2_dat[12] = '{8'h20, 8'h21, 8'h30, 8'h31, 8'h22, 8'h23,
                             8'h32, 8'h33, 8'h24, 8'h25, 8'h34, 8'h35};
  logic [7:0] e4_dat[6]  = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h60, 8'h61};

  initial begin
    for (int c = 0; c < 2; c++) begin
      s_dat[c] = '0; s_vld[c] = 1'b0; s_last[c] = 1'b0; fire[c] = 1'b0; bub[c] = 1'b0;
    end
    m_rdy   = 1'b0;
    acc_cyc = -1;

    // Reset values and single 4-beat packet from S0
    start_reset();
    step(2);
    chk("rst_m_vld", m_vld, 0);
    chk("rst_m_dat", m_dat, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_id", m_id, 0);
    chk("rst_s0_rdy", s0_rdy, 0);
    chk("rst_s1_rdy", s1_rdy, 0);
    resetn = 1'b1;
    m_rdy  = 1'b1;
    for (int i = 0; i < 4; i++) push(0, DW'(8'h10 + i), i == 3);
    wait_out("t1_count", 4, 50);
    chk("t1_latency", oq.size() > 0 ? oq[0].cyc - acc_cyc : -1, 1);
    for (int i = 0; i < oq.size(); i++) begin
      chk("t1_dat", oq[i].dat, DW'(8'h10 + i));
      chk("t1_id", oq[i].id, 0);
      chk("t1_last", oq[i].last, i == 3);
      chk("t1_b2b", oq[i].cyc - oq[0].cyc, i);
    end

    // Round robin: both sources valid from reset, three 2-beat packets each
    start_reset();
    for (int p = 0; p < 3; p++) begin
      push(0, DW'(8'h20 + 2 * p), 1'b0);
      push(0, DW'(8'h21 + 2 * p), 1'b1);
      push(1, DW'(8'h30 + 2 * p), 1'b0);
      push(1, DW'(8'h31 + 2 * p), 1'b1);
    end
    step(2);
    resetn = 1'b1;
    wait_out("t2_count", 12, 120);
    for (int i = 0; i < oq.size(); i++) begin
      chk("t2_dat", oq[i].dat, DW'(e2_dat[i]));
      chk("t2_id", oq[i].id, (i / 2) % 2);
      chk("t2_last", oq[i].last, i % 2);
    end

    // Output stall on S1 first beat
    start_reset();
    m_rdy = 1'b0;
    for (int i = 0; i < 3; i++) push(1, DW'(8'h40 + i), i == 2);
    step(2);
    resetn = 1'b1;
    for (int i = 0; i < 20 && !m_vld; i++) step(1);
    chk("t3_vld", m_vld, 1);
    for (int k = 0; k < 5; k++) begin
      chk("t3_hold_dat", m_dat, DW'(8'h40));
      chk("t3_hold_id", m_id, 1);
      chk("t3_s1_rdy", s1_rdy, 0);
      step(1);
    end
    m_rdy = 1'b1;
    wait_out("t3_count", 3, 30);
    step(5);
    chk("t3_no_dup", oq.size(), 3);
    for (int i = 0; i < oq.size(); i++) begin
      chk("t3_dat", oq[i].dat, DW'(8'h40 + i));
      chk("t3_last", oq[i].last, i == 2);
    end

    // S0 bubble mid-packet must not let S1 in
    start_reset();
    push(0, DW'(8'h50), 1'b0);
    push(0, DW'(8'h51), 1'b0);
    push_bub(0); push_bub(0); push_bub(0);
    push(0, DW'(8'h52), 1'b0);
    push(0, DW'(8'h53), 1'b1);
    push(1, DW'(8'h60), 1'b0);
    push(1, DW'(8'h61), 1'b1);
    s1_early  = 1'b0;
    mon_early = 1'b1;
    step(2);
    resetn = 1'b1;
    wait_out("t4_count", 6, 60);
    mon_early = 1'b0;
    chk("t4_s1_early", s1_early, 0);
    for (int i = 0; i < oq.size(); i++) begin
      chk("t4_dat", oq[i].dat, DW'(e4_dat[i]));
      chk("t4_id", oq[i].id, i >= 4);
    end

    // Reset during beat 2 of an S1 packet, then S0 single-beat packet
    start_reset();
    for (int i = 0; i < 3; i++) push(1, DW'(8'h70 + i), i == 2);
    step(2);
    resetn = 1'b1;
    wait_out("t5_first", 1, 30);
    chk("t5_pre_dat", m_dat, DW'(8'h71));
    chk("t5_pre_vld", m_vld, 1);
    resetn = 1'b0;
    #1;
    chk("t5_rst_s1_rdy", s1_rdy, 0);
    chk("t5_rst_s0_rdy", s0_rdy, 0);
    step(1);
    resetn = 1'b1;
    sq[1].delete();
    s_vld[1] = 1'b0;
    bub[1]   = 1'b0;
    chk("t5_m_vld", m_vld, 0);
    chk("t5_m_dat", m_dat, 0);
    chk("t5_m_last", m_last, 0);
    chk("t5_state", dut.state, IDLE);
    oq.delete();
    push(0, DW'(8'h80), 1'b1);
    wait_out("t5_count", 1, 30);
    if (oq.size() > 0) begin
      chk("t5_dat", oq[0].dat, DW'(8'h80));
      chk("t5_id", oq[0].id, 0);
      chk("t5_last", oq[0].last, 1);
    end

`ifdef ARB_PKT_COUNT_EN
    // Counter wrap on channel 0
    start_reset();
    step(2);
    resetn = 1'b1;
    step(1);
    force dut.PKT_COUNT0 = 32'hFFFF_FFFE;
    step(1);
    release dut.PKT_COUNT0;
    chk("t6_preload", cnt0, 32'hFFFF_FFFE);
    push(0, DW'(8'h90), 1'b1);
    wait_out("t6_count_a", 1, 30);
    step(2);
    chk("t6_cnt0_a", cnt0, 32'hFFFF_FFFF);
    oq.delete();
    push(0, DW'(8'h91), 1'b1);
    wait_out("t6_count_b", 1, 30);
    step(2);
    chk("t6_cnt0_b", cnt0, 32'h0000_0000);
    chk("t6_cnt1", cnt1, 32'h0000_0000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/aurora_tx_arbiter.md
AURORA_TX_ARBITER -- requirements
Module: aurora_tx_arbiter

Interface
REQ-001 Parameter: DW, 256, TDATA width of all streams (bits).
REQ-002 Port: clk  in  1  single clock for all logic; all state changes on rising edge.
REQ-003 Port: resetn  in  1  reset, synchronous, active-low.
REQ-004 Port: S0_AXIS_TDATA/TVALID/TLAST  in  DW/1/1  requester 0 stream (AXI write-request traffic).
REQ-005 Port: S0_AXIS_TREADY  out  1  requester 0 ready.
REQ-006 Port: S1_AXIS_TDATA/TVALID/TLAST  in  DW/1/1  requester 1 stream (AXI read-response traffic).
REQ-007 Port: S1_AXIS_TREADY  out  1  requester 1 ready.
REQ-008 Port: M_AXIS_TDATA/TVALID/TLAST  out  DW/1/1  merged stream to the Aurora user-data TX port.
REQ-009 Port: M_AXIS_TID  out  1  source channel of the current output beat.
REQ-010 Port: M_AXIS_TREADY  in  1  Aurora TX ready.
REQ-011 Port (only with ARB_PKT_COUNT_EN): PKT_COUNT0, PKT_COUNT1  out  32 each  packets forwarded per channel.

Function
REQ-012 FSM states: IDLE, GRANT0, GRANT1; packet-level arbitration, never interleaving beats of different packets.
REQ-013 IDLE: one requester valid -> grant it next cycle; both valid -> grant the channel not last served (round robin); none -> stay IDLE.
REQ-014 GRANTn: S(n)_AXIS_TREADY = (!M_AXIS_TVALID || M_AXIS_TREADY); other channel TREADY = 0.
REQ-015 IDLE: both TREADY = 0.
REQ-016 Beat accepted (TVALID & TREADY on granted channel) -> loaded into output register; M_AXIS_TID = n; visible on M_AXIS next cycle (latency 1).
REQ-017 Output register holds TDATA/TLAST/TID stable while M_AXIS_TVALID=1 and M_AXIS_TREADY=0.
REQ-018 M_AXIS_TVALID clears on M_AXIS_TREADY when no new beat accepted same cycle; accept and drain in same cycle -> sustained one beat/cycle.
REQ-019 Accepted beat with TLAST=1 -> next state IDLE, last-served pointer = n; one idle arbitration cycle between packets.
REQ-020 Granted channel TVALID low mid-packet -> stay in GRANTn (bubble), no re-arbitration until TLAST.
REQ-021 Single-beat packet (TLAST on first beat) handled as full packet.
REQ-022 No timeout; a stalled requester holds the link indefinitely.

Reset
REQ-023 resetn=0 on a clk edge -> state IDLE, M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TID=0, M_AXIS_TDATA=0, last-served pointer=1 (channel 0 wins first tie), counters=0.
REQ-024 Reset mid-packet discards in-flight beat and grant; no partial-packet recovery.
REQ-025 S0/S1 TREADY = 0 while resetn=0.

Configuration
REQ-026 Macro ARB_PKT_COUNT_EN defined: PKT_COUNT0/1 ports present; counter n increments by 1 on each accepted TLAST beat of channel n; wraps 0xFFFFFFFF -> 0.
REQ-027 ARB_PKT_COUNT_EN undefined: counters and ports absent; all other behaviour identical.

Structure
REQ-028 Shared package aurora_pkg holds FSM state encoding (IDLE/GRANT0/GRANT1), channel ID constants (CH_WRITE=0, CH_READ=1), counter width 32.
REQ-029 One sub-module, axis_out_reg, implements the output register stage (REQ-016..018); FSM and counters in the top.

Verification
REQ-030 S0 sends 4-beat packet (data 0x10..0x13), M_AXIS_TREADY=1 -> M beats 0x10..0x13 on consecutive cycles, TID=0, TLAST on 4th only.
REQ-031 S0 and S1 both valid from reset, 2-beat packets each, repeated 3x -> output packet order 0,1,0,1,0,1.
REQ-032 S1 packet 3 beats, M_AXIS_TREADY low 5 cycles after first output beat -> M_AXIS holds beat 1 stable, S1_TREADY=0 during stall, no data loss/duplication.
REQ-033 S0 mid-packet (beat 2 of 4) with S1 valid, S0 TVALID low 3 cycles -> S1_TREADY stays 0, S1 granted only after S0 TLAST.
REQ-034 resetn=0 for 1 cycle during beat 2 of S1 packet -> next cycle M_AXIS_TVALID=0, state IDLE; subsequent S0 single-beat packet forwarded with TID=0.
REQ-035 With ARB_PKT_COUNT_EN, counter preloaded via forcing to 0xFFFFFFFE, two S0 packets -> PKT_COUNT0 = 0xFFFFFFFF then 0x00000000; PKT_COUNT1 unchanged.
